sdp_sram_bwe: RTL and testbench

Single-clock, simple-dual-port (1R1W) synchronous RAM for AXI slave-side buffering and testbench memory models. Adds per-byte write enables, selectable read latency with a read-valid strobe, a defined read-during-write policy, and a hardware clear sequencer that fills the array with INIT_VALUE after reset or on request. dout is always driven, never tristated.

---
 rtl/sdp_sram_bwe.sv | 154 +++++++++++++++
 tb/tb_sdp_sram_bwe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_sram_bwe.sv
// Simple-dual-port (1R1W) synchronous RAM with byte-lane write enables,
// selectable read latency, a read-during-write policy and a hardware clear sweep.
module sdp_sram_bwe #(
    parameter int                        ADDR_WIDTH    = 5,
    parameter int                        DATA_WIDTH    = 32,
    parameter int                        READ_LATENCY  = 1,
    parameter int                        RDW_MODE      = 0,
    parameter bit                        INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VALUE    = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rce,
    input  logic [ADDR_WIDTH-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         rvalid,
    input  logic                         wce,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [DATA_WIDTH/8-1:0]      wbe,
    input  logic                         clr,
    output logic                         init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  wr_en;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] rd_word;

    assign init_busy = (state == CLEAR);
    assign wr_en     = (state == IDLE) && wce && we;
    assign rd_accept = (state == IDLE) && rce;

    // Sweep sequencer: one word cleared per edge, clr ignored while sweeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT_ON_RESET ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == {ADDR_WIDTH{1'b1}}) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Array contents are never reset; only the sweep or user writes change them.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[cnt] <= INIT_VALUE;
            end else if (wr_en) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wbe[i]) begin
                        mem[waddr][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        old_word    = mem[raddr];
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (wbe[i]) begin
                merged_word[8*i +: 8] = din[8*i +: 8];
            end
        end
        rd_word = old_word;
        if (wr_en && (waddr == raddr)) begin
            case (RDW_MODE)
                1:       rd_word = merged_word;
                2:       rd_word = 'x;
                default: rd_word = old_word;
            endcase
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout   <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_accept;
                    if (rd_accept) begin
                        dout <= rd_word;
                    end
                end
            end
        end else begin : g_lat2
            logic                  s1_valid;
            logic [DATA_WIDTH-1:0] s1_data;

            // The first stage captures the word at acceptance, so the
            // read-during-write result is fixed on the accepting edge.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    dout     <= '0;
                    rvalid   <= 1'b0;
                end else begin
                    s1_valid <= rd_accept;
                    if (rd_accept) begin
                        s1_data <= rd_word;
                    end
                    rvalid <= s1_valid;
                    if (s1_valid) begin
                        dout <= s1_data;
                    end
                end
            end
        end
    endgenerate

`ifndef SYNTHESIS
    task automatic print_ram(input int start, input int finish);
        for (int i = start; i <= finish; i++) begin
            $display("mem[%0d] = %h", i, mem[i[ADDR_WIDTH-1:0]]);
        end
    endtask
`endif

endmodule

// File: tb/tb_sdp_sram_bwe.sv
// Directed bench for sdp_sram_bwe: instance a uses latency 1 with old-data
// read-during-write, instance b uses latency 2 with merged-data; both share stimulus.
module tb_sdp_sram_bwe;

    logic        clk;
    logic        rst_n;
    logic        rce;
    logic [3:0]  raddr;
    logic        wce;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] din;
    logic [3:0]  wbe;
    logic        clr;

    logic [31:0] dout_a;
    logic [31:0] dout_b;
    logic        rvalid_a;
    logic        rvalid_b;
    logic        busy_a;
    logic        busy_b;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] INIT = 32'hA5A5A5A5;

    sdp_sram_bwe #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(0),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .rce(rce), .raddr(raddr), .dout(dout_a),
        .rvalid(rvalid_a), .wce(wce), .we(we), .waddr(waddr), .din(din),
        .wbe(wbe), .clr(clr), .init_busy(busy_a)
    );

    sdp_sram_bwe #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .RDW_MODE(1),
        .INIT_ON_RESET(1'b1), .INIT_VALUE(INIT)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .rce(rce), .raddr(raddr), .dout(dout_b),
        .rvalid(rvalid_b), .wce(wce), .we(we), .waddr(waddr), .din(din),
        .wbe(wbe), .clr(clr), .init_busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic writeWord(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wce = 1'b1; we = 1'b1; waddr = a; din = d; wbe = be;
        applyStimulus();
        wce = 1'b0; we = 1'b0; wbe = 4'h0;
    endtask

    task automatic readBoth(input logic [3:0] a, input logic [31:0] exp, input string tag);
        rce = 1'b1; raddr = a;
        applyStimulus();
        rce = 1'b0;
        checkOutput({tag, "_a_rvalid"}, 32'(rvalid_a), 32'd1);
        checkOutput({tag, "_a_dout"}, dout_a, exp);
        checkOutput({tag, "_b_rvalid_early"}, 32'(rvalid_b), 32'd0);
        applyStimulus();
        checkOutput({tag, "_b_rvalid"}, 32'(rvalid_b), 32'd1);
        checkOutput({tag, "_b_dout"}, dout_b, exp);
        checkOutput({tag, "_a_rvalid_drop"}, 32'(rvalid_a), 32'd0);
    endtask

    task automatic waitSweep(output int n);
        n = 0;
        while ((busy_a || busy_b) && n < 100) begin
            applyStimulus();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] burst [4];

        rst_n = 1'b0; rce = 1'b0; raddr = '0; wce = 1'b0; we = 1'b0;
        waddr = '0; din = '0; wbe = '0; clr = 1'b0;
        #1;

        // Reset state and the initial sweep
        applyStimulus();
        applyStimulus();
        checkOutput("rst_dout_a", dout_a, 32'h0);
        checkOutput("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        checkOutput("rst_busy_a", 32'(busy_a), 32'd1);
        checkOutput("rst_dout_b", dout_b, 32'h0);
        checkOutput("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        checkOutput("rst_busy_b", 32'(busy_b), 32'd1);
        rst_n = 1'b1;
        waitSweep(n);
        checkOutput("init_sweep_edges", 32'(n), 32'd16);
        checkOutput("init_busy_b_low", 32'(busy_b), 32'd0);
        readBoth(4'd7, INIT, "init_rd7");

        // Byte-lane writes
        writeWord(4'd3, 32'h0, 4'hF);
        writeWord(4'd3, 32'h11223344, 4'b0101);
        readBoth(4'd3, 32'h00220044, "bwe_rd3");
        writeWord(4'd3, 32'hFFFFFFFF, 4'b0000);
        readBoth(4'd3, 32'h00220044, "wbe0_rd3");

        // Same-address read-during-write
        writeWord(4'd5, 32'hDEADBEEF, 4'hF);
        wce = 1'b1; we = 1'b1; waddr = 4'd5; din = 32'h0; wbe = 4'b1100;
        rce = 1'b1; raddr = 4'd5;
        applyStimulus();
        wce = 1'b0; we = 1'b0; wbe = 4'h0; rce = 1'b0;
        checkOutput("rdw_a_rvalid", 32'(rvalid_a), 32'd1);
        checkOutput("rdw_a_old", dout_a, 32'hDEADBEEF);
        applyStimulus();
        checkOutput("rdw_b_rvalid", 32'(rvalid_b), 32'd1);
        checkOutput("rdw_b_new", dout_b, 32'h0000BEEF);
        readBoth(4'd5, 32'h0000BEEF, "rdw_after");

        // Different addresses do not interact
        wce = 1'b1; we = 1'b1; waddr = 4'd6; din = 32'hCAFEF00D; wbe = 4'hF;
        rce = 1'b1; raddr = 4'd5;
        applyStimulus();
        wce = 1'b0; we = 1'b0; wbe = 4'h0; rce = 1'b0;
        checkOutput("diff_a_dout", dout_a, 32'h0000BEEF);
        applyStimulus();
        checkOutput("diff_b_dout", dout_b, 32'h0000BEEF);
        readBoth(4'd6, 32'hCAFEF00D, "diff_rd6");

        // Back-to-back reads
        writeWord(4'd0, 32'h100, 4'hF);
        writeWord(4'd1, 32'h101, 4'hF);
        writeWord(4'd2, 32'h102, 4'hF);
        burst[0] = 32'h100; burst[1] = 32'h101; burst[2] = 32'h102; burst[3] = 32'h00220044;
        for (int i = 0; i < 4; i++) begin
            rce = 1'b1; raddr = 4'(i);
            applyStimulus();
            checkOutput("burst_a_rvalid", 32'(rvalid_a), 32'd1);
            checkOutput("burst_a_dout", dout_a, burst[i]);
            if (i == 0) begin
                checkOutput("burst_b_rvalid_first", 32'(rvalid_b), 32'd0);
            end else begin
                checkOutput("burst_b_rvalid", 32'(rvalid_b), 32'd1);
                checkOutput("burst_b_dout", dout_b, burst[i-1]);
            end
        end
        rce = 1'b0;
        applyStimulus();
        checkOutput("burst_a_rvalid_end", 32'(rvalid_a), 32'd0);
        checkOutput("burst_a_hold", dout_a, 32'h00220044);
        checkOutput("burst_b_rvalid_last", 32'(rvalid_b), 32'd1);
        checkOutput("burst_b_dout_last", dout_b, 32'h00220044);
        applyStimulus();
        checkOutput("burst_b_rvalid_end", 32'(rvalid_b), 32'd0);
        checkOutput("burst_b_hold", dout_b, 32'h00220044);

        // Clear request blocks user access; a second clr mid-sweep is ignored
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0;
        checkOutput("clr_busy", 32'(busy_a), 32'd1);
        wce = 1'b1; we = 1'b1; waddr = 4'd2; din = 32'h12345678; wbe = 4'hF;
        rce = 1'b1; raddr = 4'd4;
        applyStimulus();
        n = 1;
        wce = 1'b0; we = 1'b0; wbe = 4'h0; rce = 1'b0;
        checkOutput("clr_a_no_rvalid", 32'(rvalid_a), 32'd0);
        checkOutput("clr_a_hold", dout_a, 32'h00220044);
        applyStimulus();
        n++;
        checkOutput("clr_b_no_rvalid", 32'(rvalid_b), 32'd0);
        checkOutput("clr_b_hold", dout_b, 32'h00220044);
        while ((busy_a || busy_b) && n < 100) begin
            clr = (n == 5);
            applyStimulus();
            n++;
        end
        clr = 1'b0;
        checkOutput("clr_sweep_edges", 32'(n), 32'd16);
        readBoth(4'd2, INIT, "clr_rd2");
        readBoth(4'd4, INIT, "clr_rd4");

        // Reset in the middle of a sweep restarts it from address 0
        writeWord(4'd0, 32'h0000BAD0, 4'hF);
        writeWord(4'd9, 32'h0000BAD9, 4'hF);
        writeWord(4'd15, 32'h0000BADF, 4'hF);
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0;
        repeat (6) applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("midrst_busy", 32'(busy_a), 32'd1);
        checkOutput("midrst_dout_a", dout_a, 32'h0);
        checkOutput("midrst_dout_b", dout_b, 32'h0);
        rst_n = 1'b1;
        waitSweep(n);
        checkOutput("midrst_sweep_edges", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            readBoth(4'(i), INIT, "midrst_rd");
        end

        // In-flight read dropped by reset
        writeWord(4'd3, 32'h00000033, 4'hF);
        rce = 1'b1; raddr = 4'd3;
        applyStimulus();
        rce = 1'b0;
        checkOutput("inflight_a_rvalid", 32'(rvalid_a), 32'd1);
        checkOutput("inflight_a_dout", dout_a, 32'h00000033);
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("inflight_b_rvalid", 32'(rvalid_b), 32'd0);
        checkOutput("inflight_b_dout", dout_b, 32'h0);
        checkOutput("inflight_a_dout_rst", dout_a, 32'h0);
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("inflight_b_rvalid_late", 32'(rvalid_b), 32'd0);
        waitSweep(n);
        checkOutput("inflight_sweep_edges", 32'(n), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
